// File: rtl/regfile_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_arbiter_pkg
// Description : Shared core constants and types for the register-file
//               write-back arbiter (data width, register address width,
//               queue defaults, selection source encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_writeback_arbiter_pkg;

  localparam int CORE_XLEN         = 32;
  localparam int REG_ADDR_W        = 5;
  localparam int CORE_WB_DEPTH     = 4;
  localparam int CORE_STARVE_LIMIT = 8;

  typedef logic [REG_ADDR_W-1:0] regAddr_t;

  // Which producer owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_EXT  = 2'd2
  } wbSel_t;

  // x0 is hard-wired to zero, so writes to it are never real requests.
  function automatic logic isRealDest(input regAddr_t rd);
    return rd != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_arbiter_if
// Description : Bundle of the ALU result, multi-cycle result handshake,
//               register-file write port, hazard query and status signals.
//               master = pipeline side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_writeback_arbiter_if
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) ();

  logic            alu_valid;
  regAddr_t        alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ext_valid;
  logic            ext_ready;
  regAddr_t        ext_rd;
  logic [XLEN-1:0] ext_data;

  logic            rf_we;
  regAddr_t        rf_rd;
  logic [XLEN-1:0] rf_wdata;

  regAddr_t        qry_rs;
  logic            qry_pending;

  logic            stall_req;
  logic            idle;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ext_valid, ext_rd, ext_data,
    input  ext_ready,
    input  rf_we, rf_rd, rf_wdata,
    output qry_rs,
    input  qry_pending, stall_req, idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ext_valid, ext_rd, ext_data,
    output ext_ready,
    output rf_we, rf_rd, rf_wdata,
    input  qry_rs,
    output qry_pending, stall_req, idle
  );

endinterface
`default_nettype wire

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular result queue for multi-cycle units. Push is ignored
//               when full, pop is ignored when empty. Also answers whether
//               any valid entry targets a queried register.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int DEPTH = CORE_WB_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  regAddr_t        i_pushRd,
  input  logic [XLEN-1:0] i_pushData,
  input  logic            i_pop,
  output regAddr_t        o_headRd,
  output logic [XLEN-1:0] o_headData,
  output logic            o_full,
  output logic            o_empty,
  input  regAddr_t        i_qryRs,
  output logic            o_qryHit
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  regAddr_t         r_rdMem   [DEPTH];
  logic [XLEN-1:0]  r_dataMem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;
  logic [DEPTH-1:0] w_entryHit;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_doPush   = i_push && !o_full;
  assign w_doPop    = i_pop && !o_empty;
  assign o_headRd   = r_rdMem[r_rdPtr];
  assign o_headData = r_dataMem[r_rdPtr];

  // Entry storage; stale slots are masked by the occupancy logic, so no reset.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_rdMem[r_wrPtr]   <= i_pushRd;
      r_dataMem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_doPush && w_doPop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] w_offset;
    assign w_offset       = PTR_W'(gi) - r_rdPtr;
    assign w_entryHit[gi] = ({1'b0, w_offset} < r_count) && (r_rdMem[gi] == i_qryRs);
  end

  assign o_qryHit = isRealDest(i_qryRs) && (|w_entryHit);

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_arbiter
// Description : Arbitrates the single register-file write port between the
//               single-cycle ALU (always wins, no backpressure) and a queue
//               of multi-cycle unit results. Requests a pipeline bubble when
//               the queue head has been starved for too long.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int XLEN         = CORE_XLEN,
  parameter int DEPTH        = CORE_WB_DEPTH,
  parameter int STARVE_LIMIT = CORE_STARVE_LIMIT
) (
  input  logic                        clk,
  input  logic                        rst,
  regfile_writeback_arbiter_if.slave  wb
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                w_aluReq;
  logic                w_extReady;
  logic                w_push;
  logic                w_pop;
  logic                w_fifoFull;
  logic                w_fifoEmpty;
  logic                w_qryHit;
  regAddr_t            w_headRd;
  logic [XLEN-1:0]     w_headData;
  wbSel_t              w_sel;
  regAddr_t            w_selRd;
  logic [XLEN-1:0]     w_selData;
  logic [STARVE_W-1:0] w_starveNext;

  logic                r_rfWe;
  regAddr_t            r_rfRd;
  logic [XLEN-1:0]     r_rfWdata;
  logic [STARVE_W-1:0] r_starveCnt;
  logic                r_stall;

  // Readiness depends only on occupancy: a full queue refuses even if the
  // head leaves this cycle, keeping the handshake free of the pop path.
  assign w_aluReq   = wb.alu_valid && isRealDest(wb.alu_rd);
  assign w_extReady = !w_fifoFull;
  assign w_push     = wb.ext_valid && w_extReady && isRealDest(wb.ext_rd);

  wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_wbFifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushRd   (wb.ext_rd),
    .i_pushData (wb.ext_data),
    .i_pop      (w_pop),
    .o_headRd   (w_headRd),
    .o_headData (w_headData),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty),
    .i_qryRs    (wb.qry_rs),
    .o_qryHit   (w_qryHit)
  );

  // Fixed priority: ALU first, then queue head; the head pops only when chosen.
  always_comb begin
    w_sel     = SEL_NONE;
    w_selRd   = '0;
    w_selData = '0;
    w_pop     = 1'b0;
    if (w_aluReq) begin
      w_sel     = SEL_ALU;
      w_selRd   = wb.alu_rd;
      w_selData = wb.alu_data;
    end else if (!w_fifoEmpty) begin
      w_sel     = SEL_EXT;
      w_selRd   = w_headRd;
      w_selData = w_headData;
      w_pop     = 1'b1;
    end
  end

  // Starvation age of the head; saturates so the stall stays up until a pop.
  always_comb begin
    w_starveNext = r_starveCnt;
    if (w_fifoEmpty || w_pop) begin
      w_starveNext = '0;
    end else if (r_starveCnt < STARVE_W'(STARVE_LIMIT)) begin
      w_starveNext = r_starveCnt + STARVE_W'(1);
    end
  end

  // Registered write port and stall request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rfWe      <= 1'b0;
      r_rfRd      <= '0;
      r_rfWdata   <= '0;
      r_starveCnt <= '0;
      r_stall     <= 1'b0;
    end else begin
      r_rfWe      <= (w_sel != SEL_NONE);
      r_rfRd      <= w_selRd;
      r_rfWdata   <= w_selData;
      r_starveCnt <= w_starveNext;
      r_stall     <= (w_starveNext >= STARVE_W'(STARVE_LIMIT));
    end
  end

  assign wb.ext_ready   = w_extReady;
  assign wb.rf_we       = r_rfWe;
  assign wb.rf_rd       = r_rfRd;
  assign wb.rf_wdata    = r_rfWdata;
  assign wb.qry_pending = w_qryHit;
  assign wb.stall_req   = r_stall;
  assign wb.idle        = w_fifoEmpty && !r_rfWe;

endmodule
`default_nettype wire
